// File: rtl/jtag_tap_gen2.sv
// IEEE 1149.1 TAP controller with BYPASS, IDCODE and variable-length custom DRs.
// Define JTAG_TAP_SHIFT_GUARD_EN to gate custom updates on an exact Shift-DR count (adds cust_rg_abort_o).
module jtag_tap_gen2 #(
  parameter logic [31:0] IDCODE = 32'h1000_563D,
  parameter int IR_WIDTH = 5,
  parameter int MAX_DR_WIDTH = 41,
  parameter logic [IR_WIDTH-1:0] ADDR_IDCODE = 5'h01,
  parameter int NUM_CUST_REGS = 2,
  parameter logic [((NUM_CUST_REGS > 0) ? NUM_CUST_REGS : 1)*IR_WIDTH-1:0] CUST_REG_ADDRS = {5'h11, 5'h10},
  parameter logic [((NUM_CUST_REGS > 0) ? NUM_CUST_REGS : 1)*8-1:0] CUST_REG_WIDTHS = {8'd41, 8'd32},
  parameter int CUST_ADDRW = (NUM_CUST_REGS > 1) ? $clog2(NUM_CUST_REGS) : 1
) (
  input  logic                    tck_i,
  input  logic                    trst_n_i,
  input  logic                    tms_i,
  input  logic                    tdi_i,
  output logic                    tdo_o,
  output logic                    tdo_oe_o,
  output logic                    tlr_o,
  output logic                    cust_rg_sel_o,
  output logic [CUST_ADDRW-1:0]   cust_rg_addr_o,
  output logic                    cust_rg_capture_o,
  output logic                    cust_rg_update_o,
`ifdef JTAG_TAP_SHIFT_GUARD_EN
  output logic                    cust_rg_abort_o,
`endif
  output logic [MAX_DR_WIDTH-1:0] cust_rg_dat_o,
  input  logic [MAX_DR_WIDTH-1:0] cust_rg_dat_i,
  output logic [3:0]              state_o
);

  localparam int DRW = (MAX_DR_WIDTH > 32) ? MAX_DR_WIDTH : 32;

  typedef enum logic [3:0] {
    TLR, RTI, SEL_DR, CAP_DR, SH_DR, EX1_DR, PAU_DR, EX2_DR, UPD_DR,
    SEL_IR, CAP_IR, SH_IR, EX1_IR, PAU_IR, EX2_IR, UPD_IR
  } tap_state_e;

  tap_state_e state, state_next;
  logic [IR_WIDTH-1:0] ir, ir_shift;
  logic [DRW-1:0] dr_shift, dr_shifted, dr_capture, len_mask, top_bit;
  logic is_idcode, cust_hit;
  logic [CUST_ADDRW-1:0] cust_idx;
  logic [7:0] dr_len;

  always_ff @(posedge tck_i) begin
    if (!trst_n_i) state <= TLR;
    else state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      TLR:    state_next = tms_i ? TLR    : RTI;
      RTI:    state_next = tms_i ? SEL_DR : RTI;
      SEL_DR: state_next = tms_i ? SEL_IR : CAP_DR;
      CAP_DR: state_next = tms_i ? EX1_DR : SH_DR;
      SH_DR:  state_next = tms_i ? EX1_DR : SH_DR;
      EX1_DR: state_next = tms_i ? UPD_DR : PAU_DR;
      PAU_DR: state_next = tms_i ? EX2_DR : PAU_DR;
      EX2_DR: state_next = tms_i ? UPD_DR : SH_DR;
      UPD_DR: state_next = tms_i ? SEL_DR : RTI;
      SEL_IR: state_next = tms_i ? TLR    : CAP_IR;
      CAP_IR: state_next = tms_i ? EX1_IR : SH_IR;
      SH_IR:  state_next = tms_i ? EX1_IR : SH_IR;
      EX1_IR: state_next = tms_i ? UPD_IR : PAU_IR;
      PAU_IR: state_next = tms_i ? EX2_IR : PAU_IR;
      EX2_IR: state_next = tms_i ? UPD_IR : SH_IR;
      UPD_IR: state_next = tms_i ? SEL_DR : RTI;
      default: state_next = TLR;
    endcase
  end

  // All-ones always means BYPASS; among custom entries the lowest index wins.
  always_comb begin
    is_idcode = 1'b0;
    cust_hit  = 1'b0;
    cust_idx  = '0;
    dr_len    = 8'd1;
    if (ir != '1) begin
      if (ir == ADDR_IDCODE) begin
        is_idcode = 1'b1;
        dr_len    = 8'd32;
      end else begin
        for (int i = NUM_CUST_REGS - 1; i >= 0; i--) begin
          if (ir == CUST_REG_ADDRS[i*IR_WIDTH +: IR_WIDTH]) begin
            cust_hit = 1'b1;
            cust_idx = CUST_ADDRW'(i);
            dr_len   = CUST_REG_WIDTHS[i*8 +: 8];
          end
        end
      end
    end
  end

  // Shift only bits [L-1:0]; tdi enters at bit L-1 and everything above stays zero.
  always_comb begin
    top_bit    = DRW'(1) << (dr_len - 8'd1);
    len_mask   = (top_bit << 1) - DRW'(1);
    dr_shifted = ((dr_shift >> 1) & len_mask & ~top_bit) | (tdi_i ? top_bit : '0);
    if (is_idcode) dr_capture = DRW'(IDCODE);
    else if (cust_hit) dr_capture = DRW'(cust_rg_dat_i) & len_mask;
    else dr_capture = '0;
  end

  always_ff @(posedge tck_i) begin
    if (!trst_n_i) begin
      ir       <= ADDR_IDCODE;
      ir_shift <= '0;
      dr_shift <= '0;
    end else begin
      if (state_next == TLR) ir <= ADDR_IDCODE;
      else if (state == UPD_IR) ir <= ir_shift;
      case (state)
        CAP_IR: ir_shift <= IR_WIDTH'(2'b01);
        SH_IR:  ir_shift <= {tdi_i, ir_shift[IR_WIDTH-1:1]};
        CAP_DR: dr_shift <= dr_capture;
        SH_DR:  dr_shift <= dr_shifted;
        default: ;
      endcase
    end
  end

`ifdef JTAG_TAP_SHIFT_GUARD_EN
  logic [7:0] shift_cnt;

  always_ff @(posedge tck_i) begin
    if (!trst_n_i) shift_cnt <= '0;
    else if (state == CAP_DR) shift_cnt <= '0;
    else if (state == SH_DR && shift_cnt != 8'hFF) shift_cnt <= shift_cnt + 8'd1;
  end
`endif

  always_comb begin
    tlr_o             = (state == TLR);
    cust_rg_sel_o     = cust_hit;
    cust_rg_addr_o    = cust_idx;
    cust_rg_capture_o = (state == CAP_DR) && cust_hit;
`ifdef JTAG_TAP_SHIFT_GUARD_EN
    cust_rg_update_o  = (state == UPD_DR) && cust_hit && (shift_cnt == dr_len);
    cust_rg_abort_o   = (state == UPD_DR) && cust_hit && (shift_cnt != dr_len);
`else
    cust_rg_update_o  = (state == UPD_DR) && cust_hit;
`endif
  end

  always_ff @(negedge tck_i) begin
    if (!trst_n_i) begin
      tdo_o    <= 1'b0;
      tdo_oe_o <= 1'b0;
    end else if (state == SH_IR) begin
      tdo_o    <= ir_shift[0];
      tdo_oe_o <= 1'b1;
    end else if (state == SH_DR) begin
      tdo_o    <= dr_shift[0];
      tdo_oe_o <= 1'b1;
    end else begin
      tdo_o    <= 1'b0;
      tdo_oe_o <= 1'b0;
    end
  end

  assign cust_rg_dat_o = dr_shift[MAX_DR_WIDTH-1:0];
  assign state_o       = state;

endmodule

// File: tb/tb_jtag_tap_gen2.sv
// Bench for jtag_tap_gen2: scan-level model predicts every pin per cycle; scoreboard compares on negedge.
module tb_jtag_tap_gen2;
  localparam int IRW = 5;
  localparam int DW = 41;
  localparam logic [31:0] ID_VAL = 32'h1000_563D;
`ifdef JTAG_TAP_SHIFT_GUARD_EN
  localparam bit GUARD = 1'b1;
`else
  localparam bit GUARD = 1'b0;
`endif

  // clock / reset
  logic tck = 1'b0;
  always #5 tck = ~tck;

  logic trst_n, tms, tdi;
  logic tdo, tdo_oe, tlr, sel, cap, upd;
  logic [0:0] addr;
  logic [DW-1:0] dat_o, dat_i;
  logic [3:0] state_dbg;
`ifdef JTAG_TAP_SHIFT_GUARD_EN
  logic abt;
`endif

  jtag_tap_gen2 dut (
    .tck_i(tck),
    .trst_n_i(trst_n),
    .tms_i(tms),
    .tdi_i(tdi),
    .tdo_o(tdo),
    .tdo_oe_o(tdo_oe),
    .tlr_o(tlr),
    .cust_rg_sel_o(sel),
    .cust_rg_addr_o(addr),
    .cust_rg_capture_o(cap),
    .cust_rg_update_o(upd),
`ifdef JTAG_TAP_SHIFT_GUARD_EN
    .cust_rg_abort_o(abt),
`endif
    .cust_rg_dat_o(dat_o),
    .cust_rg_dat_i(dat_i),
    .state_o(state_dbg)
  );

  typedef struct packed {
    logic chk;
    logic tlr;
    logic oe;
    logic tdo;
    logic sel;
    logic [0:0] addr;
    logic cap;
    logic upd;
    logic abt;
    logic chkd;
    logic [DW-1:0] dat;
  } exp_t;
  localparam int EW = $bits(exp_t);

  logic [EW-1:0] exp_q[$];
  int errors = 0;
  int checks = 0;
  int cyc_n = 0;
  logic [IRW-1:0] m_ir;
  logic [IRW-1:0] cust_addr [2] = '{5'h10, 5'h11};
  int cust_len [2] = '{32, 41};

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s cycle=%0d got=%0h want=%0h", name, cyc_n, act, exp);
    end
  endtask

  // Selection rules: all-ones -> bypass, IDCODE code -> 32 bits, else first matching custom entry.
  function automatic void decode(input logic [IRW-1:0] ir, output logic s, output logic [0:0] ix,
                                 output int len, output logic idc);
    s = 1'b0; ix = '0; len = 1; idc = 1'b0;
    if (ir == 5'h1F) begin
      len = 1;
    end else if (ir == 5'h01) begin
      idc = 1'b1; len = 32;
    end else begin
      for (int i = 0; i < 2; i++) begin
        if (!s && ir == cust_addr[i]) begin
          s = 1'b1; ix = 1'(i); len = cust_len[i];
        end
      end
    end
  endfunction

  function automatic exp_t mk(input logic t, input logic oe, input logic d, input logic c, input logic u,
                              input logic a, input logic cd, input logic [DW-1:0] dv);
    exp_t e;
    logic s, idc;
    logic [0:0] ix;
    int l;
    decode(m_ir, s, ix, l, idc);
    e.chk = 1'b1; e.tlr = t; e.oe = oe; e.tdo = d; e.sel = s; e.addr = ix;
    e.cap = c; e.upd = u; e.abt = a; e.chkd = cd; e.dat = dv;
    return e;
  endfunction

  function automatic exp_t idle();
    return mk(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, '0);
  endfunction

  function automatic exp_t shiftv(input logic d);
    return mk(1'b0, 1'b1, d, 1'b0, 1'b0, 1'b0, 1'b0, '0);
  endfunction

  function automatic exp_t tlrv();
    return mk(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, '0);
  endfunction

  // driver: one TCK cycle; the record describes the state entered at this cycle's posedge
  task automatic tick(input logic t, input logic d, input logic rn, input exp_t e);
    tms = t; tdi = d; trst_n = rn;
    exp_q.push_back(e);
    @(posedge tck);
    @(negedge tck);
    #3;
  endtask

  task automatic reset_tap();
    m_ir = 5'h01;
    tick(1'b1, 1'b0, 1'b0, tlrv());
    tick(1'b1, 1'b0, 1'b0, tlrv());
    tick(1'b1, 1'b0, 1'b1, tlrv());
  endtask

  task automatic goto_rti();
    tick(1'b0, 1'b0, 1'b1, idle());
  endtask

  task automatic random_walk(input int m);
    for (int i = 0; i < m; i++) begin
      dat_i = DW'({$urandom, $urandom});
      tick(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'b1, '0);
    end
  endtask

  task automatic tms_reset();
    for (int i = 0; i < 4; i++) tick(1'b1, 1'b0, 1'b1, '0);
    m_ir = 5'h01;
    tick(1'b1, 1'b0, 1'b1, tlrv());
  endtask

  task automatic scan_ir(input logic [IRW-1:0] v, output logic [63:0] out);
    logic q[$];
    out = '0;
    q = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
    tick(1'b1, 1'b0, 1'b1, idle());
    tick(1'b1, 1'b0, 1'b1, idle());
    tick(1'b0, 1'b0, 1'b1, idle());
    tick(1'b0, 1'b0, 1'b1, shiftv(q[0]));
    for (int k = 0; k < IRW; k++) begin
      out[k] = tdo;
      void'(q.pop_front());
      q.push_back(v[k]);
      if (k < IRW - 1) tick(1'b0, v[k], 1'b1, shiftv(q[0]));
      else tick(1'b1, v[k], 1'b1, idle());
    end
    tick(1'b1, 1'b0, 1'b1, idle());
    m_ir = v;
    tick(1'b0, 1'b0, 1'b1, idle());
  endtask

  task automatic scan_dr(input int n, input logic [63:0] data, input int pause_at, input logic [DW-1:0] capval,
                         output logic [63:0] out, output logic [DW-1:0] got);
    logic q[$];
    logic s, idc, u, a, last;
    logic [0:0] ix;
    logic [63:0] capw;
    logic [DW-1:0] pk;
    int l;
    out = '0;
    decode(m_ir, s, ix, l, idc);
    capw = idc ? 64'(ID_VAL) : (s ? 64'(capval) : 64'd0);
    for (int i = 0; i < l; i++) q.push_back(capw[i]);
    dat_i = capval;
    tick(1'b1, 1'b0, 1'b1, idle());
    tick(1'b0, 1'b0, 1'b1, mk(1'b0, 1'b0, 1'b0, s, 1'b0, 1'b0, 1'b0, '0));
    tick(1'b0, 1'b0, 1'b1, shiftv(q[0]));
    for (int k = 0; k < n; k++) begin
      out[k] = tdo;
      void'(q.pop_front());
      q.push_back(data[k]);
      last = (k == n - 1);
      if (last) begin
        tick(1'b1, data[k], 1'b1, idle());
      end else if (k == pause_at - 1) begin
        tick(1'b1, data[k], 1'b1, idle());
        for (int p = 0; p < 3; p++) tick(1'b0, 1'b0, 1'b1, idle());
        tick(1'b1, 1'b0, 1'b1, idle());
        tick(1'b0, 1'b0, 1'b1, shiftv(q[0]));
      end else begin
        tick(1'b0, data[k], 1'b1, shiftv(q[0]));
      end
    end
    pk = '0;
    for (int i = 0; i < q.size(); i++) pk[i] = q[i];
    u = s && (!GUARD || n == l);
    a = GUARD && s && (n != l);
    tick(1'b1, 1'b0, 1'b1, mk(1'b0, 1'b0, 1'b0, 1'b0, u, a, u, pk));
    got = dat_o;
    tick(1'b0, 1'b0, 1'b1, idle());
  endtask

  // Reset in the middle of a Shift-DR pass: scan abandoned, no update or abort.
  task automatic reset_mid_scan(input int k);
    logic q[$];
    logic s, idc;
    logic [0:0] ix;
    int l;
    logic [63:0] capw;
    decode(m_ir, s, ix, l, idc);
    dat_i = DW'({$urandom, $urandom});
    capw = idc ? 64'(ID_VAL) : (s ? 64'(dat_i) : 64'd0);
    for (int i = 0; i < l; i++) q.push_back(capw[i]);
    tick(1'b1, 1'b0, 1'b1, idle());
    tick(1'b0, 1'b0, 1'b1, mk(1'b0, 1'b0, 1'b0, s, 1'b0, 1'b0, 1'b0, '0));
    tick(1'b0, 1'b0, 1'b1, shiftv(q[0]));
    for (int j = 0; j < k; j++) begin
      logic b;
      b = 1'($urandom_range(0, 1));
      void'(q.pop_front());
      q.push_back(b);
      tick(1'b0, b, 1'b1, shiftv(q[0]));
    end
    m_ir = 5'h01;
    tick(1'b0, 1'b0, 1'b0, tlrv());
    tick(1'b1, 1'b0, 1'b1, tlrv());
  endtask

  // scoreboard
  initial begin
    exp_t e;
    forever begin
      @(negedge tck);
      #2;
      cyc_n++;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        if (e.chk) begin
          chk("tlr", 64'(tlr), 64'(e.tlr));
          chk("tdo_oe", 64'(tdo_oe), 64'(e.oe));
          chk("tdo", 64'(tdo), 64'(e.tdo));
          chk("sel", 64'(sel), 64'(e.sel));
          chk("addr", 64'(addr), 64'(e.addr));
          chk("capture", 64'(cap), 64'(e.cap));
          chk("update", 64'(upd), 64'(e.upd));
`ifdef JTAG_TAP_SHIFT_GUARD_EN
          chk("abort", 64'(abt), 64'(e.abt));
`endif
          if (e.chkd) chk("dat_o", 64'(dat_o), 64'(e.dat));
        end
      end
    end
  end

  initial begin
    #2_000_000;
    errors++;
    $display("FAIL watchdog cycle=%0d got=running want=finished", cyc_n);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    logic [63:0] o;
    logic [DW-1:0] d;
    tms = 1'b1; tdi = 1'b0; trst_n = 1'b0; dat_i = '0; m_ir = 5'h01;

    reset_tap();
    goto_rti();
    scan_dr(32, 64'($urandom), 0, '0, o, d);
    chk("idcode_out", o[31:0], 64'h1000_563D);

    random_walk(9);
    tms_reset();
    goto_rti();
    scan_ir(5'h1F, o);
    chk("ir_capture", o[4:0], 64'h01);
    scan_dr(9, 64'h0A5, 0, '0, o, d);
    chk("bypass_out", o[8:0], 64'h14A);

    scan_ir(5'h11, o);
    chk("ir_capture2", o[4:0], 64'h01);
    scan_dr(41, 64'h0_DEAD_BEEF_3, 0, 41'h1_2345_6789_A, o, d);
    chk("cust41_out", o[40:0], 64'h1_2345_6789_A);
    chk("cust41_dat", 64'(d), 64'h0_DEAD_BEEF_3);

    scan_ir(5'h10, o);
    scan_dr(32, 64'hCAFE_1234, 20, 41'h1_5555_AAAA_F, o, d);
    chk("pause_dat", 64'(d), 64'hCAFE_1234);
    chk("pause_out", o[31:0], 64'h555A_AAAF);

    scan_dr(31, {$urandom, $urandom}, 0, DW'({$urandom, $urandom}), o, d);
    scan_dr(32, {$urandom, $urandom}, 0, DW'({$urandom, $urandom}), o, d);
    reset_mid_scan(10);
    goto_rti();
    scan_ir(5'h11, o);
    reset_mid_scan(40);
    goto_rti();

    for (int it = 0; it < 25; it++) begin
      logic [IRW-1:0] irv;
      int n, p, sk;
      sk = $urandom_range(0, 4);
      case (sk)
        0: irv = 5'h01;
        1: irv = 5'h1F;
        2: irv = 5'h10;
        3: irv = 5'h11;
        default: irv = 5'($urandom);
      endcase
      scan_ir(irv, o);
      n = $urandom_range(1, 45);
      p = ($urandom_range(0, 2) == 0) ? $urandom_range(1, n) : 0;
      scan_dr(n, {$urandom, $urandom}, p, DW'({$urandom, $urandom}), o, d);
      if ($urandom_range(0, 5) == 0) begin
        random_walk($urandom_range(1, 12));
        tms_reset();
        goto_rti();
      end
    end

    chk("queue_drain", 64'(exp_q.size()), 64'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
